// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, controller states, flag bundle.
package alu_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SLT = 3'b101,
      OP_SHL = 3'b110,
      OP_MUL = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
   } flags_t;

endpackage

// File: rtl/seq_mul.sv
// Unsigned shift-add multiplier. Iteration 0 is folded into the start edge so the
// full product is registered after WIDTH-1 further cycles; done_o then flags it for
// one cycle (WIDTH cycles from start to the edge that consumes the product).
module seq_mul #(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [PW-1:0]    mcand_q, mcand_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             run_q, run_d;

   // Next-state for one shift-add step, or reload on start.
   always_comb begin
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      if (start_i) begin
         prod_d   = b_i[0] ? PW'(a_i) : '0;
         mcand_d  = PW'(a_i) << 1;
         mplier_d = b_i >> 1;
         cnt_d    = CW'(1);
         run_d    = 1'b1;
      end else if (run_q) begin
         if (cnt_q == CW'(WIDTH)) begin
            run_d = 1'b0;
         end else begin
            if (mplier_q[0]) prod_d = prod_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
         end
      end
   end

   // Iterator registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
      end
   end

   assign done_o    = run_q & (cnt_q == CW'(WIDTH));
   assign product_o = prod_q;

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU with registered result and NZCV flags.
// Build option SEQ_ALU_MUL_EN enables the multi-cycle multiplier; without it,
// op MUL completes in one cycle with result 0 and illegal=1.
module seq_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             ovf,
   output logic             illegal,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   flags_t           flags_q, flags_d;
   logic             illegal_q, illegal_d;

   op_t              op_in;
   logic             accept;
   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shl_ext;
   logic [WIDTH-1:0] calc_res;
   logic             calc_carry;
   logic             calc_ovf;
   logic             calc_illegal;

`ifdef SEQ_ALU_MUL_EN
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   seq_mul #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .reset     (reset),
      .start_i   (mul_start),
      .a_i       (a),
      .b_i       (b),
      .done_o    (mul_done),
      .product_o (mul_prod)
   );
`endif

   assign op_in    = op_t'(op);
   assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
   assign accept   = in_valid & in_ready;

   // Single-cycle datapath: conditional-invert adder, logic ops, SLT, SHL.
   always_comb begin
      is_sub       = (op_in == OP_SUB);
      b_eff        = is_sub ? ~b : b;
      sum          = (WIDTH+1)'(a) + (WIDTH+1)'(b_eff) + (WIDTH+1)'(is_sub);
      shl_ext      = (WIDTH+1)'(a) << b[SHW-1:0];
      calc_res     = '0;
      calc_carry   = 1'b0;
      calc_ovf     = 1'b0;
      calc_illegal = 1'b0;
      case (op_in)
         OP_ADD, OP_SUB: begin
            calc_res   = sum[WIDTH-1:0];
            calc_carry = sum[WIDTH];
            calc_ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: calc_res = a & b;
         OP_OR:  calc_res = a | b;
         OP_XOR: calc_res = a ^ b;
         OP_SLT: calc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SHL: begin
            calc_res   = shl_ext[WIDTH-1:0];
            calc_carry = shl_ext[WIDTH];
         end
         OP_MUL: begin
`ifndef SEQ_ALU_MUL_EN
            calc_illegal = 1'b1;
`endif
         end
         default: calc_res = '0;
      endcase
   end

   // Controller next-state and result/flag load.
   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      flags_d   = flags_q;
      illegal_d = illegal_q;
`ifdef SEQ_ALU_MUL_EN
      mul_start = 1'b0;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if ((state_q == ST_DONE) && out_ready) state_d = ST_IDLE;
            if (accept) begin
`ifdef SEQ_ALU_MUL_EN
               if (op_in == OP_MUL) begin
                  state_d   = ST_MUL;
                  mul_start = 1'b1;
               end else
`endif
               begin
                  state_d       = ST_DONE;
                  result_d      = calc_res;
                  flags_d.zero  = (calc_res == '0);
                  flags_d.neg   = calc_res[WIDTH-1];
                  flags_d.carry = calc_carry;
                  flags_d.ovf   = calc_ovf;
                  illegal_d     = calc_illegal;
               end
            end
         end
         ST_MUL: begin
`ifdef SEQ_ALU_MUL_EN
            if (mul_done) begin
               state_d       = ST_DONE;
               result_d      = mul_prod[WIDTH-1:0];
               flags_d.zero  = (mul_prod[WIDTH-1:0] == '0);
               flags_d.neg   = mul_prod[WIDTH-1];
               flags_d.carry = |mul_prod[2*WIDTH-1:WIDTH];
               flags_d.ovf   = 1'b0;
               illegal_d     = 1'b0;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         result_q  <= '0;
         flags_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         flags_q   <= flags_d;
         illegal_q <= illegal_d;
      end
   end

   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign zero      = flags_q.zero;
   assign neg       = flags_q.neg;
   assign carry     = flags_q.carry;
   assign ovf       = flags_q.ovf;
   assign illegal   = illegal_q;
`ifdef SEQ_ALU_MUL_EN
   assign busy      = (state_q == ST_MUL);
`else
   assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=4; MUL checks follow the SEQ_ALU_MUL_EN build.
module tb_seq_alu;

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3,
                          XOR = 3'd4, SLT = 3'd5, SHL = 3'd6, MUL = 3'd7;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] op = 3'd0;
   logic [3:0] a = 4'd0;
   logic [3:0] b = 4'd0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [3:0] result;
   logic       zero, neg, carry, ovf, illegal, busy;
   logic [3:0] flg;

   int n_vec = 0;
   int n_err = 0;

   assign flg = {zero, neg, carry, ovf};

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .neg(neg), .carry(carry), .ovf(ovf),
      .illegal(illegal), .busy(busy)
   );

   typedef struct {
      logic [2:0] o;
      logic [3:0] x;
      logic [3:0] y;
      logic [3:0] r;
      logic [3:0] f;   // {zero, neg, carry, ovf}
   } vec_t;

   vec_t vecs [15] = '{
      '{ADD, 4'h7, 4'h9, 4'h0, 4'b1010},
      '{ADD, 4'h7, 4'h1, 4'h8, 4'b0101},
      '{SUB, 4'h3, 4'h5, 4'hE, 4'b0100},
      '{SLT, 4'hF, 4'h1, 4'h1, 4'b0000},
      '{SLT, 4'h1, 4'hF, 4'h0, 4'b1000},
      '{AND, 4'hC, 4'hA, 4'h8, 4'b0100},
      '{OR,  4'h5, 4'h2, 4'h7, 4'b0000},
      '{XOR, 4'h6, 4'h6, 4'h0, 4'b1000},
      '{SHL, 4'h9, 4'h1, 4'h2, 4'b0010},
      '{SHL, 4'hB, 4'h0, 4'hB, 4'b0100},
      '{SHL, 4'h3, 4'h6, 4'hC, 4'b0100},
      '{SUB, 4'h5, 4'h5, 4'h0, 4'b1010},
      '{SUB, 4'h8, 4'h1, 4'h7, 4'b0011},
      '{ADD, 4'hF, 4'h1, 4'h0, 4'b1010},
      '{ADD, 4'h4, 4'h4, 4'h8, 4'b0101}
   };

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one accepting edge, then scramble operands.
   task automatic issue(input string tag, input logic [2:0] o, input logic [3:0] x,
                        input logic [3:0] y);
      in_valid = 1'b1;
      op = o; a = x; b = y;
      #1;
      chk({tag, "/in_ready"}, 8'(in_ready), 8'd1);
      step();
      in_valid = 1'b0;
      a = ~x; b = ~y; op = 3'd2;
   endtask

   task automatic check_res(input string tag, input logic [3:0] r, input logic [3:0] f,
                            input logic il);
      chk({tag, "/out_valid"}, 8'(out_valid), 8'd1);
      chk({tag, "/result"}, 8'(result), 8'(r));
      chk({tag, "/flags"}, 8'(flg), 8'(f));
      chk({tag, "/illegal"}, 8'(illegal), 8'(il));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state.
      step();
      step();
      chk("rst/out_valid", 8'(out_valid), 8'd0);
      chk("rst/busy", 8'(busy), 8'd0);
      chk("rst/result", 8'(result), 8'd0);
      chk("rst/flags", 8'(flg), 8'd0);
      chk("rst/illegal", 8'(illegal), 8'd0);
      chk("rst/in_ready", 8'(in_ready), 8'd1);
      reset = 1'b0;
      step();

      // Back-to-back single-cycle vectors with out_ready=1.
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         issue($sformatf("vec%0d", i), vecs[i].o, vecs[i].x, vecs[i].y);
         check_res($sformatf("vec%0d", i), vecs[i].r, vecs[i].f, 1'b0);
      end
      step();
      chk("drain/out_valid", 8'(out_valid), 8'd0);

      // Backpressure: hold ADD result, then XOR accepted on the releasing edge.
      out_ready = 1'b0;
      issue("bp_add", ADD, 4'h2, 4'h3);
      in_valid = 1'b1; op = XOR; a = 4'hF; b = 4'h5;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bp%0d/in_ready", i), 8'(in_ready), 8'd0);
         check_res($sformatf("bp%0d", i), 4'h5, 4'b0000, 1'b0);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_rel/in_ready", 8'(in_ready), 8'd1);
      step();
      in_valid = 1'b0;
      check_res("bp_xor", 4'hA, 4'b0100, 1'b0);
      step();
      chk("bp_idle/out_valid", 8'(out_valid), 8'd0);

`ifdef SEQ_ALU_MUL_EN
      // MUL 5*3 then back-to-back MUL 6*7.
      issue("mul53", MUL, 4'h5, 4'h3);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("mul53_c%0d/busy", i + 1), 8'(busy), 8'd1);
         chk($sformatf("mul53_c%0d/out_valid", i + 1), 8'(out_valid), 8'd0);
         chk($sformatf("mul53_c%0d/in_ready", i + 1), 8'(in_ready), 8'd0);
         step();
      end
      check_res("mul53", 4'hF, 4'b0100, 1'b0);
      chk("mul53/busy", 8'(busy), 8'd0);
      issue("mul67", MUL, 4'h6, 4'h7);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("mul67_c%0d/busy", i + 1), 8'(busy), 8'd1);
         step();
      end
      check_res("mul67", 4'hA, 4'b0110, 1'b0);

      // Reset on cycle 2 of a MUL.
      issue("mulrst", MUL, 4'h3, 4'h3);
      step();
      reset = 1'b1;
      #1;
      chk("mulrst/busy", 8'(busy), 8'd0);
      chk("mulrst/out_valid", 8'(out_valid), 8'd0);
      chk("mulrst/result", 8'(result), 8'd0);
      chk("mulrst/flags", 8'(flg), 8'd0);
      step();
      reset = 1'b0;
      #1;
      chk("mulrst/in_ready", 8'(in_ready), 8'd1);
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("mulrst_p%0d/out_valid", i), 8'(out_valid), 8'd0);
         chk($sformatf("mulrst_p%0d/busy", i), 8'(busy), 8'd0);
      end
`else
      // MUL without the multiplier: one-cycle illegal result.
      issue("mul_off", MUL, 4'h5, 4'h3);
      check_res("mul_off", 4'h0, 4'b1000, 1'b1);
      chk("mul_off/busy", 8'(busy), 8'd0);
      issue("after_mul_off", ADD, 4'h2, 4'h3);
      check_res("after_mul_off", 4'h5, 4'b0000, 1'b0);
      chk("after_mul_off/busy", 8'(busy), 8'd0);
      step();
`endif

      // Asynchronous reset while holding a result in DONE.
      out_ready = 1'b0;
      issue("arst", ADD, 4'h7, 4'h1);
      check_res("arst_pre", 4'h8, 4'b0101, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("arst/out_valid", 8'(out_valid), 8'd0);
      chk("arst/result", 8'(result), 8'd0);
      chk("arst/flags", 8'(flg), 8'd0);
      step();
      reset = 1'b0;
      #1;
      chk("arst/in_ready", 8'(in_ready), 8'd1);
      step();
      chk("arst_post/out_valid", 8'(out_valid), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the 4-bit add/sub ALU for the processor datapath.
- Single-cycle ops: ADD, SUB, AND, OR, XOR, SLT, SHL.
- Multi-cycle unsigned shift-add MUL.
- Registered result with NZCV-style flags; valid/ready on both input and output, so the controller can stall on MUL.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).
- SHW, $clog2(WIDTH), shift-amount bits taken from b for SHL.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- op  in  3  opcode (op_t)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero, neg, carry, ovf  out  1 each  registered flags
- illegal  out  1  op not supported in this build
- busy  out  1  MUL iteration in progress

Interface (already decided):
- Clock clk.
- reset is asynchronous, active-high.

Behaviour:
- States:
  - IDLE
  - MUL: multiplier iterating
  - DONE: holding output
- Reset (async) from any state, including mid-MUL:
  - state=IDLE.
  - result, all flags, out_valid, illegal, busy = 0.
  - In-flight operation is discarded.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational; no dependence on in_valid.
- Accept = in_valid & in_ready. Operands and op are captured on the accepting edge; a/b may change afterwards.
- Single-cycle op accepted:
  - Next state DONE.
  - out_valid=1 on the following cycle (latency 1).
- MUL accepted:
  - State MUL, busy=1 for exactly WIDTH cycles, then DONE.
  - out_valid asserts WIDTH+1 cycles after accept.
- DONE:
  - result/flags/out_valid held stable while out_ready=0.
  - If out_ready=1 and no new accept: IDLE, out_valid=0.
  - If out_ready=1 with a new accept in the same cycle: back-to-back. A single-cycle op stays in DONE with new data; MUL goes to MUL.
- Arithmetic (mod 2^WIDTH):
  - ADD: a+b; carry = carry-out; ovf = signed overflow.
  - SUB: a+~b+1; carry = carry-out (1 = no borrow, a>=b unsigned); ovf = signed overflow.
  - AND/OR/XOR: bitwise; carry=0, ovf=0.
  - SLT: result = (signed a < signed b) ? 1 : 0; carry=0, ovf=0.
  - SHL: a << b[SHW-1:0]; carry = last bit shifted out (0 if shift 0); ovf=0.
  - MUL: unsigned a*b, result = low WIDTH bits; carry = |high WIDTH bits; ovf=0.
- Flags on every op: zero = (result==0); neg = result[WIDTH-1].
- illegal = 0 except as defined under Optional Feature. It is updated with every result.
- Unused opcodes do not exist; all 8 encodings are defined.

Optional Feature:
- Macro SEQ_ALU_MUL_EN.
- Defined: MUL behaves as above.
- Undefined:
  - No multiplier logic; state MUL is unreachable; busy is tied 0.
  - op MUL completes as a single-cycle op with result=0, zero=1, neg=0, carry=0, ovf=0, illegal=1.

Decomposition:
- Package alu_pkg:
  - op_t enum: ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLT=101, SHL=110, MUL=111.
  - state_t: IDLE, MUL, DONE.
  - flags_t packed struct {zero, neg, carry, ovf}.
- Sub-module seq_mul: shift-add iterator with start, done, WIDTH-bit a/b and 2*WIDTH-bit product. Instantiated only under SEQ_ALU_MUL_EN.
- Add/sub uses the existing conditional-invert adder scheme inline.

Test Plan (WIDTH=4):
- ADD a=7, b=9 -> 1 cycle later: result=0, zero=1, carry=1, ovf=0. ADD 7+1 -> result=8, neg=1, ovf=1, carry=0.
- SUB a=3, b=5 -> result=0xE, neg=1, carry=0, ovf=0. SLT a=0xF, b=1 -> result=1.
- MUL 5*3 -> busy=1 for 4 cycles, out_valid at cycle 5, result=0xF, carry=0. MUL 6*7 -> result=0xA, carry=1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles after an ADD: result/flags stable, in_ready=0.
  - Then drive out_ready=1 with a new XOR request in the same cycle: next cycle shows the XOR result, with no bubble.
- Reset asserted on cycle 2 of a MUL -> all outputs 0 immediately, in_ready=1 after release, no stale out_valid.
- Build without SEQ_ALU_MUL_EN, op=MUL a=5, b=3 -> 1 cycle later: result=0, illegal=1, busy never asserted.
